bit_capture_sequencer: RTL
==========================

// Module: bit_capture_sequencer
// PURPOSE
//  Sequences sampling of a serial bit stream into the 1-bit display storage RAM of the bit plotter.
//  Generates the prescaled sample tick, write strobe and write address for the RAM's write port.
//  Supports arm/abort, edge or immediate triggering and a pre-trigger window (circular buffer).
//  Reports trigger and oldest-sample addresses so the VGA side can unroll the buffer for display.
// PARAMETERS
//  ADDR_WIDTH      14  storage address width; DEPTH = 2**ADDR_WIDTH samples
//  PRESCALE_WIDTH  15  width of prescale setting
//  PRE_SAMPLES     0   samples kept before trigger; legal range 0..DEPTH-1
// PORTS
//  clk           in   1               system clock; everything synchronous to its rising edge
//  reset         in   1               asynchronous, active-high reset
//  arm           in   1               start a capture (pulse; level accepted, see rules)
//  abort         in   1               cancel capture in progress
//  triggerMode   in   2               00 immediate, 01 rising, 10 falling, 11 either edge
//  prescale      in   PRESCALE_WIDTH  sample every prescale+1 clocks; latched on arm
//  bitIn         in   1               data bit, already synchronous to clk
//  writeEnable   out  1               RAM write strobe, one cycle per sample
//  writeIndex    out  ADDR_WIDTH      RAM write address
//  writeData     out  1               RAM write data
//  busy          out  1               capture in progress (PRE/WAIT_TRIG/POST)
//  done          out  1               capture complete; held until next accepted arm
//  triggerIndex  out  ADDR_WIDTH      address of trigger sample; valid while done
//  startIndex    out  ADDR_WIDTH      triggerIndex-PRE_SAMPLES mod DEPTH (oldest sample); valid while done
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; write pointer, prescale counter, post counter 0.
//  States: IDLE, PRE, WAIT_TRIG, POST, DONE. busy=1 exactly in PRE/WAIT_TRIG/POST.
//  Arm accepted only in IDLE or DONE: latch prescale, ptr<=0, cnt<=0, prev-sample invalid, done<=0,
//   next state PRE (WAIT_TRIG if PRE_SAMPLES==0). arm while busy ignored.
//  abort in any busy state -> IDLE next edge, no further writes, done stays 0. abort beats arm.
//   abort in IDLE/DONE: no effect (done retained).
//  Tick: in busy states, edge with cnt==0 is a tick and reloads cnt<=latched prescale; else cnt--.
//   First tick on the edge after arm acceptance; subsequent ticks every prescale+1 clocks.
//  On each tick: writeEnable<=1, writeIndex<=ptr, writeData<=bitIn, ptr<=ptr+1 (wraps mod DEPTH),
//   prev<=bitIn, prev valid. writeEnable is 0 on every non-tick edge (strobe exactly 1 cycle).
//   Latency: bitIn sampled at tick edge appears on writeData in the same registered update.
//  PRE: after PRE_SAMPLES ticks -> WAIT_TRIG. No trigger evaluation in PRE.
//  WAIT_TRIG: each tick sample written (ptr wraps freely). Trigger condition on tick sample s:
//   immediate: always; rising: prev valid & prev==0 & s==1; falling: prev valid & prev==1 & s==0;
//   either: prev valid & prev!=s. On trigger: triggerIndex<=ptr (that sample's address),
//   startIndex<=ptr-PRE_SAMPLES mod DEPTH, postCnt<=DEPTH-PRE_SAMPLES-1;
//   -> POST, or straight to DONE if postCnt would be 0.
//  POST: each tick writes and decrements postCnt; tick with postCnt==1 is the last write.
//   On that edge state->DONE, busy<=0, done<=1 together with final writeEnable.
//  Total writes after trigger, inclusive: DEPTH-PRE_SAMPLES; buffer holds exactly DEPTH samples
//   from startIndex onward, never overwriting pre-trigger samples.
//  triggerMode sampled live on each WAIT_TRIG tick (not latched).
//  DONE/IDLE: no writes, pointers frozen, triggerIndex/startIndex held.
//  Reset mid-capture: immediate return to reset state; no write strobe after reset asserts.
// TESTING (bench: ADDR_WIDTH=4, DEPTH=16, PRE_SAMPLES=4)
//  Immediate, prescale=0, arm 1 cycle -> writeEnable 16 consecutive cycles starting 1 edge after
//   arm accept; writeIndex 0..15; triggerIndex=4, startIndex=0; done with last strobe.
//  prescale=2 -> strobes spaced exactly 3 clocks; writeData equals bitIn at each tick edge.
//  Rising mode, bitIn low 40 ticks then high -> ptr wraps in WAIT_TRIG; triggerIndex = addr of first
//   high sample (40 mod 16=8); startIndex=4; exactly 12 strobes from trigger inclusive.
//  Falling mode, bitIn constant 1 -> busy stays 1, done 0 indefinitely; abort -> IDLE next edge.
//  arm and abort same cycle while busy -> IDLE; arm during POST ignored; re-arm in DONE clears done.
//  Assert reset during POST -> all outputs 0 asynchronously; next arm restarts at writeIndex 0.

Source files
------------

// File: rtl/bit_capture_sequencer_if.sv
// ---------------------------------------------------------------------------
// bit_capture_sequencer_if
// Groups the control, sample-stream and RAM-write-port signals of the bit
// capture sequencer.
//   master : capture controller side (drives arm/abort/mode/prescale/bitIn,
//            observes the write port and status)
//   slave  : the sequencer itself
// Signals:
//   arm, abort, triggerMode[1:0], prescale[PRESCALE_WIDTH-1:0], bitIn
//   writeEnable, writeIndex[ADDR_WIDTH-1:0], writeData
//   busy, done, triggerIndex[ADDR_WIDTH-1:0], startIndex[ADDR_WIDTH-1:0]
// ---------------------------------------------------------------------------
interface bit_capture_sequencer_if #(
    parameter int ADDR_WIDTH     = 14,
    parameter int PRESCALE_WIDTH = 15
);
    logic                      arm;
    logic                      abort;
    logic [1:0]                triggerMode;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      bitIn;
    logic                      writeEnable;
    logic [ADDR_WIDTH-1:0]     writeIndex;
    logic                      writeData;
    logic                      busy;
    logic                      done;
    logic [ADDR_WIDTH-1:0]     triggerIndex;
    logic [ADDR_WIDTH-1:0]     startIndex;

    modport master (
        output arm, abort, triggerMode, prescale, bitIn,
        input  writeEnable, writeIndex, writeData, busy, done, triggerIndex, startIndex
    );

    modport slave (
        input  arm, abort, triggerMode, prescale, bitIn,
        output writeEnable, writeIndex, writeData, busy, done, triggerIndex, startIndex
    );
endinterface

// File: rtl/bit_capture_sequencer.sv
// ---------------------------------------------------------------------------
// bit_capture_sequencer
// Samples a serial bit stream into a 1-bit display RAM (2**ADDR_WIDTH deep)
// used as a circular buffer. A prescaled tick paces sampling; optional
// pre-trigger samples are kept so the oldest sample sits at startIndex and
// the trigger sample at triggerIndex once done.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : slave side of bit_capture_sequencer_if (control in, RAM write
//            port and status out)
// ---------------------------------------------------------------------------
module bit_capture_sequencer #(
    parameter int ADDR_WIDTH     = 14,
    parameter int PRESCALE_WIDTH = 15,
    parameter int PRE_SAMPLES    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    bit_capture_sequencer_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]     PRE_COUNT = ADDR_WIDTH'(PRE_SAMPLES);
    // Pointer value of the last pre-trigger tick (unused when PRE_SAMPLES==0).
    localparam logic [ADDR_WIDTH-1:0]     PRE_LAST  = ADDR_WIDTH'(PRE_SAMPLES - 1);
    // Remaining writes after the trigger sample itself.
    localparam logic [ADDR_WIDTH-1:0]     POST_INIT = ADDR_WIDTH'(DEPTH - PRE_SAMPLES - 1);
    localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE   = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;

    state_t                    state_reg, state_next;
    logic [PRESCALE_WIDTH-1:0] prescale_reg, prescale_next;
    logic [PRESCALE_WIDTH-1:0] cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0]     ptr_reg, ptr_next;
    logic [ADDR_WIDTH-1:0]     post_cnt_reg, post_cnt_next;
    logic                      prev_reg, prev_next;
    logic                      prev_valid_reg, prev_valid_next;
    logic                      we_reg, we_next;
    logic [ADDR_WIDTH-1:0]     widx_reg, widx_next;
    logic                      wdata_reg, wdata_next;
    logic                      done_reg, done_next;
    logic [ADDR_WIDTH-1:0]     trig_idx_reg, trig_idx_next;
    logic [ADDR_WIDTH-1:0]     start_idx_reg, start_idx_next;
    logic                      trig_hit;

    // Trigger condition on the sample taken this tick; mode is read live.
    always_comb begin
        trig_hit = 1'b0;
        case (bus.triggerMode)
            2'b00:   trig_hit = 1'b1;
            2'b01:   trig_hit = prev_valid_reg & ~prev_reg & bus.bitIn;
            2'b10:   trig_hit = prev_valid_reg & prev_reg & ~bus.bitIn;
            default: trig_hit = prev_valid_reg & (prev_reg ^ bus.bitIn);
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        prescale_next   = prescale_reg;
        cnt_next        = cnt_reg;
        ptr_next        = ptr_reg;
        post_cnt_next   = post_cnt_reg;
        prev_next       = prev_reg;
        prev_valid_next = prev_valid_reg;
        we_next         = 1'b0;
        widx_next       = widx_reg;
        wdata_next      = wdata_reg;
        done_next       = done_reg;
        trig_idx_next   = trig_idx_reg;
        start_idx_next  = start_idx_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (bus.arm) begin
                    prescale_next   = bus.prescale;
                    cnt_next        = '0;
                    ptr_next        = '0;
                    prev_valid_next = 1'b0;
                    done_next       = 1'b0;
                    state_next      = (PRE_SAMPLES == 0) ? WAIT_TRIG : PRE;
                end
            end
            default: begin
                if (bus.abort) begin
                    // Abort wins over everything, including a pending tick.
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    cnt_next        = prescale_reg;
                    we_next         = 1'b1;
                    widx_next       = ptr_reg;
                    wdata_next      = bus.bitIn;
                    ptr_next        = ptr_reg + ADDR_ONE;
                    prev_next       = bus.bitIn;
                    prev_valid_next = 1'b1;
                    case (state_reg)
                        PRE: begin
                            // ptr counts pre-trigger ticks; it cannot wrap here.
                            if (ptr_reg == PRE_LAST)
                                state_next = WAIT_TRIG;
                        end
                        WAIT_TRIG: begin
                            if (trig_hit) begin
                                trig_idx_next  = ptr_reg;
                                start_idx_next = ptr_reg - PRE_COUNT;
                                post_cnt_next  = POST_INIT;
                                if (POST_INIT == '0) begin
                                    state_next = DONE;
                                    done_next  = 1'b1;
                                end else begin
                                    state_next = POST;
                                end
                            end
                        end
                        default: begin
                            post_cnt_next = post_cnt_reg - ADDR_ONE;
                            if (post_cnt_reg == ADDR_ONE) begin
                                state_next = DONE;
                                done_next  = 1'b1;
                            end
                        end
                    endcase
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            prescale_reg   <= '0;
            cnt_reg        <= '0;
            ptr_reg        <= '0;
            post_cnt_reg   <= '0;
            prev_reg       <= 1'b0;
            prev_valid_reg <= 1'b0;
            we_reg         <= 1'b0;
            widx_reg       <= '0;
            wdata_reg      <= 1'b0;
            done_reg       <= 1'b0;
            trig_idx_reg   <= '0;
            start_idx_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            prescale_reg   <= prescale_next;
            cnt_reg        <= cnt_next;
            ptr_reg        <= ptr_next;
            post_cnt_reg   <= post_cnt_next;
            prev_reg       <= prev_next;
            prev_valid_reg <= prev_valid_next;
            we_reg         <= we_next;
            widx_reg       <= widx_next;
            wdata_reg      <= wdata_next;
            done_reg       <= done_next;
            trig_idx_reg   <= trig_idx_next;
            start_idx_reg  <= start_idx_next;
        end
    end

    assign bus.writeEnable  = we_reg;
    assign bus.writeIndex   = widx_reg;
    assign bus.writeData    = wdata_reg;
    assign bus.busy         = (state_reg == PRE) || (state_reg == WAIT_TRIG) || (state_reg == POST);
    assign bus.done         = done_reg;
    assign bus.triggerIndex = trig_idx_reg;
    assign bus.startIndex   = start_idx_reg;
endmodule
